// File: rtl/mips_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mips_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Operation encoding: bit 1 selects divide, bit 0 selects signed.
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_SIGN = 2'b10
    } state_e;

endpackage

// File: rtl/mips_muldiv_unit_sign_adjust.sv
// Sign handling for the mul/div unit: operand magnitudes on entry and
// conditional two's-complement correction of the raw result on exit.
module mips_sign_adjust #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               is_signed_i,
    output logic [WIDTH-1:0]   a_abs_o,
    output logic [WIDTH-1:0]   b_abs_o,
    output logic               sign_a_o,
    output logic               sign_b_o,
    input  logic [2*WIDTH-1:0] res_i,
    input  logic               is_mul_i,
    input  logic               neg_q_i,
    input  logic               neg_r_i,
    output logic [2*WIDTH-1:0] res_o
);

    // Magnitudes; unsigned ops pass operands through untouched.
    always_comb begin
        sign_a_o = is_signed_i & a_i[WIDTH-1];
        sign_b_o = is_signed_i & b_i[WIDTH-1];
        a_abs_o  = sign_a_o ? (~a_i + 1'b1) : a_i;
        b_abs_o  = sign_b_o ? (~b_i + 1'b1) : b_i;
    end

    // MUL negates the full double-width product; DIV fixes quotient (low)
    // and remainder (high) independently.
    always_comb begin
        res_o = res_i;
        if (is_mul_i) begin
            if (neg_q_i) res_o = ~res_i + 1'b1;
        end else begin
            if (neg_q_i) res_o[WIDTH-1:0]       = ~res_i[WIDTH-1:0] + 1'b1;
            if (neg_r_i) res_o[2*WIDTH-1:WIDTH] = ~res_i[2*WIDTH-1:WIDTH] + 1'b1;
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle over a shared
// 2*WIDTH accumulator: {upper/remainder, lower/multiplier/quotient}.
module mips_muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d, divz_q, divz_d;

    logic [WIDTH-1:0]   a_abs, b_abs;
    logic               sign_a, sign_b;
    logic [2*WIDTH-1:0] res_adj;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step, div_step;
    logic [WIDTH:0]     rem_sh;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_sub;

    mips_sign_adjust #(.WIDTH(WIDTH)) u_sign (
        .a_i         (operandA),
        .b_i         (operandB),
        .is_signed_i (op[0]),
        .a_abs_o     (a_abs),
        .b_abs_o     (b_abs),
        .sign_a_o    (sign_a),
        .sign_b_o    (sign_b),
        .res_i       (acc_q),
        .is_mul_i    (~is_div_q),
        .neg_q_i     (neg_q_q),
        .neg_r_i     (neg_r_q),
        .res_o       (res_adj)
    );

    // Single iteration datapaths for multiply and restoring divide.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
        mul_step = {mul_sum, acc_q[WIDTH-1:1]};
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_ge   = rem_sh >= {1'b0, mcand_q};
        rem_sub  = rem_sh[WIDTH-1:0] - mcand_q;
        div_step = {(rem_ge ? rem_sub : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};
    end

    // Next-state and datapath control for IDLE -> CALC -> SIGN -> IDLE.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        divz_d   = divz_q;
        case (state_q)
            ST_IDLE: begin
                if (hi_we) hi_d = wr_data;
                if (lo_we) lo_d = wr_data;
                if (start) begin
                    state_d  = ST_CALC;
                    busy_d   = 1'b1;
                    divz_d   = 1'b0;
                    cnt_d    = '0;
                    is_div_d = op[1];
                    dz_d     = op[1] & (operandB == '0);
                    // Divide by zero leaves the all-ones quotient alone; the
                    // remainder correction still restores operandA exactly.
                    neg_q_d  = (sign_a ^ sign_b) & ~(op[1] & (operandB == '0));
                    neg_r_d  = sign_a;
                    if (op[1]) begin
                        acc_d   = {{WIDTH{1'b0}}, a_abs};
                        mcand_d = b_abs;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, b_abs};
                        mcand_d = a_abs;
                    end
                end
            end
            ST_CALC: begin
                acc_d = is_div_q ? div_step : mul_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = ST_SIGN;
            end
            ST_SIGN: begin
                {hi_d, lo_d} = res_adj;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                divz_d  = dz_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            divz_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            divz_q   <= divz_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = divz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: latency, arithmetic, div-by-zero,
// busy-time ignores, back-to-back start, and reset abort.
module tb_mips_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operandA = '0, operandB = '0, wr_data = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int vecs = 0;
    int errs = 0;

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operandA(operandA), .operandB(operandB),
        .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
        .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Drive a start for one edge; returns #1 after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; operandA = a; operandB = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count edges until done (bounded); also counts busy-high cycles.
    task automatic wait_done(output int cyc, output int bcnt);
        cyc = 0;
        bcnt = busy ? 1 : 0;
        while (cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (busy) bcnt++;
            if (done) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vecs++;
        if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
            errs++; $display("FAIL reset_state: got %h want 0", {busy, done, div_zero, hi, lo});
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        int cyc, bc;
        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(cyc, bc);
        vecs++; if (cyc !== 33) begin errs++; $display("FAIL multu_latency: got %0d want 33", cyc); end
        vecs++; if (hi !== 32'hFFFFFFFE) begin errs++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        vecs++; if (lo !== 32'h00000001) begin errs++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        @(negedge clk);
        issue(2'b01, 32'hFFFFFFF9, 32'd3);
        wait_done(cyc, bc);
        vecs++; if (bc !== 33) begin errs++; $display("FAIL mult_busy_cycles: got %0d want 33", bc); end
        vecs++; if (hi !== 32'hFFFFFFFF) begin errs++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        vecs++; if (lo !== 32'hFFFFFFEB) begin errs++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
        @(posedge clk); #1;
        vecs++; if (done !== 1'b0) begin errs++; $display("FAIL done_one_cycle: got %b want 0", done); end
        @(negedge clk);
    endtask

    task automatic test_div();
        int cyc, bc;
        issue(2'b11, 32'hFFFFFFF9, 32'd2);
        wait_done(cyc, bc);
        vecs++; if (lo !== 32'hFFFFFFFD) begin errs++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        vecs++; if (hi !== 32'hFFFFFFFF) begin errs++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        @(negedge clk);
        issue(2'b10, 32'd100, 32'd7);
        wait_done(cyc, bc);
        vecs++; if (lo !== 32'd14) begin errs++; $display("FAIL divu_lo: got %h want 0000000e", lo); end
        vecs++; if (hi !== 32'd2) begin errs++; $display("FAIL divu_hi: got %h want 00000002", hi); end
        @(negedge clk);
        issue(2'b11, 32'h80000000, 32'hFFFFFFFF);
        wait_done(cyc, bc);
        vecs++; if ({hi, lo} !== 64'h00000000_80000000) begin
            errs++; $display("FAIL div_overflow: got %h want 0000000080000000", {hi, lo});
        end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int cyc, bc;
        issue(2'b10, 32'h1234, 32'h0);
        wait_done(cyc, bc);
        vecs++; if (cyc !== 33) begin errs++; $display("FAIL dz_latency: got %0d want 33", cyc); end
        vecs++; if (lo !== 32'hFFFFFFFF) begin errs++; $display("FAIL dz_lo: got %h want ffffffff", lo); end
        vecs++; if (hi !== 32'h1234) begin errs++; $display("FAIL dz_hi: got %h want 00001234", hi); end
        vecs++; if (div_zero !== 1'b1) begin errs++; $display("FAIL dz_flag: got %b want 1", div_zero); end
        @(negedge clk);
        issue(2'b11, 32'hFFFFFFF9, 32'h0);
        wait_done(cyc, bc);
        vecs++; if ({hi, lo} !== 64'hFFFFFFF9_FFFFFFFF) begin
            errs++; $display("FAIL dz_signed: got %h want fffffff9ffffffff", {hi, lo});
        end
        @(negedge clk);
        issue(2'b00, 32'd2, 32'd3);
        vecs++; if (div_zero !== 1'b0) begin errs++; $display("FAIL dz_clear: got %b want 0", div_zero); end
        wait_done(cyc, bc);
        vecs++; if ({hi, lo} !== 64'd6) begin errs++; $display("FAIL mul_small: got %h want 6", {hi, lo}); end
        @(negedge clk);
    endtask

    task automatic test_mt_with_start();
        int cyc, bc;
        hi_we = 1'b1; wr_data = 32'hCAFEF00D;
        issue(2'b00, 32'd3, 32'd5);
        hi_we = 1'b0;
        vecs++; if (hi !== 32'hCAFEF00D) begin errs++; $display("FAIL mt_start_hi: got %h want cafef00d", hi); end
        wait_done(cyc, bc);
        vecs++; if ({hi, lo} !== 64'd15) begin errs++; $display("FAIL mt_start_result: got %h want f", {hi, lo}); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        issue(2'b01, 32'hFFFFFFFB, 32'd4);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1; op = 2'b00; operandA = 32'd1; operandB = 32'd1;
        hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        vecs++; if ({hi, lo} !== 64'd15) begin errs++; $display("FAIL busy_mt_ignored: got %h want f", {hi, lo}); end
        wait_done(cyc, bc);
        vecs++; if (cyc + 10 !== 33) begin errs++; $display("FAIL busy_start_latency: got %0d want 33", cyc + 10); end
        vecs++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEC) begin
            errs++; $display("FAIL busy_start_ignored: got %h want ffffffffffffffec", {hi, lo});
        end
        // Start in the done cycle itself.
        issue(2'b10, 32'd100, 32'd7);
        vecs++; if ({busy, done} !== 2'b10) begin errs++; $display("FAIL b2b_accept: got %b want 10", {busy, done}); end
        wait_done(cyc, bc);
        vecs++; if ({hi, lo} !== {32'd2, 32'd14}) begin
            errs++; $display("FAIL b2b_result: got %h want 000000020000000e", {hi, lo});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int dn;
        issue(2'b11, 32'd100, 32'd7);
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        vecs++; if ({busy, done, hi, lo} !== 66'd0) begin
            errs++; $display("FAIL abort_state: got %h want 0", {busy, done, hi, lo});
        end
        reset = 1'b1;
        dn = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        vecs++; if (dn !== 0) begin errs++; $display("FAIL abort_no_done: got %0d want 0", dn); end
        lo_we = 1'b1; wr_data = 32'hA5A5A5A5;
        @(posedge clk); #1;
        lo_we = 1'b0;
        vecs++; if ({hi, lo} !== 64'h00000000_A5A5A5A5) begin
            errs++; $display("FAIL mtlo: got %h want 00000000a5a5a5a5", {hi, lo});
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_mt_with_start();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
